// File: rtl/hsv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hsv_pkg
//  Description : Shared constants and sector encodings for the HSV->RGB path.
//  Revision    : 1.0  initial release
// ============================================================================
package hsv_pkg;

    localparam int H_MAX      = 359;
    localparam int SECTOR_DEG = 60;
    localparam int PIX_MAX    = 255;
    localparam int LATENCY    = 4;

    localparam logic [2:0] SEC_0 = 3'd0;
    localparam logic [2:0] SEC_1 = 3'd1;
    localparam logic [2:0] SEC_2 = 3'd2;
    localparam logic [2:0] SEC_3 = 3'd3;
    localparam logic [2:0] SEC_4 = 3'd4;
    localparam logic [2:0] SEC_5 = 3'd5;

endpackage
`default_nettype wire

// File: rtl/hsv2rgb_div255.sv
`default_nettype none
// ============================================================================
//  Module      : div255
//  Description : Combinational floor(x/255) for x in 0..65025.
//  Revision    : 1.0  initial release
// ============================================================================
module div255 (
    input  logic [15:0] x,
    output logic [7:0]  q
);

    // (x + (x >> 8) + 1) >> 8 equals floor(x/255) for every 16-bit x whose
    // quotient fits in 8 bits, so no correction step is needed.
    logic [16:0] sum;

    // Reciprocal-free quotient estimate that is exact over the used range
    always_comb begin
        sum = {1'b0, x} + {9'd0, x[15:8]} + 17'd1;
        q   = 8'(sum >> 8);
    end

endmodule
`default_nettype wire

// File: rtl/hsv2rgb.sv
`default_nettype none
// ============================================================================
//  Module      : hsv2rgb
//  Description : 4-stage free-running HSV (H 0..359, S/V 0..255) to 8-bit RGB
//                converter with a valid flag travelling beside the data.
//  Revision    : 1.0  initial release
// ============================================================================
module hsv2rgb
    import hsv_pkg::*;
#(
    parameter int LATENCY = hsv_pkg::LATENCY,
    parameter int H_MAX   = hsv_pkg::H_MAX
) (
    input  logic       clk_Image_Process,
    input  logic       Rst,
    input  logic       HSV_Valid,
    input  logic [8:0] HSV_H,
    input  logic [7:0] HSV_S,
    input  logic [7:0] HSV_V,
    output logic       RGB_Valid,
    output logic [7:0] RGB_Data_R,
    output logic [7:0] RGB_Data_G,
    output logic [7:0] RGB_Data_B,
    output logic [2:0] Delay_Num
);

    assign Delay_Num = 3'(LATENCY);

    // ---------------- S1: clamp hue, split into sector and offset ----------
    logic [8:0] h_clamp;
    logic [2:0] sec_c;
    logic [5:0] f_c;

    logic       s1_valid;
    logic [2:0] s1_sec;
    logic [5:0] s1_f;
    logic [7:0] s1_s;
    logic [7:0] s1_v;

    // Clamp then locate the 60-degree sector by compare-subtract
    always_comb begin
        h_clamp = (HSV_H > 9'(H_MAX)) ? 9'(H_MAX) : HSV_H;
        sec_c   = SEC_0;
        f_c     = 6'(h_clamp);
        if (h_clamp >= 9'd300) begin
            sec_c = SEC_5;
            f_c   = 6'(h_clamp - 9'd300);
        end else if (h_clamp >= 9'd240) begin
            sec_c = SEC_4;
            f_c   = 6'(h_clamp - 9'd240);
        end else if (h_clamp >= 9'd180) begin
            sec_c = SEC_3;
            f_c   = 6'(h_clamp - 9'd180);
        end else if (h_clamp >= 9'd120) begin
            sec_c = SEC_2;
            f_c   = 6'(h_clamp - 9'd120);
        end else if (h_clamp >= 9'd60) begin
            sec_c = SEC_1;
            f_c   = 6'(h_clamp - 9'd60);
        end
    end

    // Stage-1 register
    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            s1_valid <= 1'b0;
            s1_sec   <= SEC_0;
            s1_f     <= '0;
            s1_s     <= '0;
            s1_v     <= '0;
        end else begin
            s1_valid <= HSV_Valid;
            s1_sec   <= sec_c;
            s1_f     <= f_c;
            s1_s     <= HSV_S;
            s1_v     <= HSV_V;
        end
    end

    // ---------------- S2: scaled ramps a = S*f/60, b = S*(60-f)/60 --------
    logic [13:0] prod_a;
    logic [13:0] prod_b;
    logic [7:0]  a_c;
    logic [7:0]  b_c;

    logic       s2_valid;
    logic [2:0] s2_sec;
    logic [7:0] s2_s;
    logic [7:0] s2_v;
    logic [7:0] s2_a;
    logic [7:0] s2_b;

    // Ramp products; maximum 255*60 fits in 14 bits
    always_comb begin
        prod_a = {6'd0, s1_s} * {8'd0, s1_f};
        prod_b = {6'd0, s1_s} * (14'(SECTOR_DEG) - {8'd0, s1_f});
        a_c    = 8'(prod_a / 14'(SECTOR_DEG));
        b_c    = 8'(prod_b / 14'(SECTOR_DEG));
    end

    // Stage-2 register
    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            s2_valid <= 1'b0;
            s2_sec   <= SEC_0;
            s2_s     <= '0;
            s2_v     <= '0;
            s2_a     <= '0;
            s2_b     <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_sec   <= s1_sec;
            s2_s     <= s1_s;
            s2_v     <= s1_v;
            s2_a     <= a_c;
            s2_b     <= b_c;
        end
    end

    // ---------------- S3: V times complements ----------------------------
    logic [15:0] mp_c;
    logic [15:0] mq_c;
    logic [15:0] mt_c;

    logic        s3_valid;
    logic [2:0]  s3_sec;
    logic [7:0]  s3_v;
    logic [15:0] s3_mp;
    logic [15:0] s3_mq;
    logic [15:0] s3_mt;

    // 8x8 products; the complements never underflow since a,b,S <= 255
    always_comb begin
        mp_c = {8'd0, s2_v} * {8'd0, 8'(PIX_MAX) - s2_s};
        mq_c = {8'd0, s2_v} * {8'd0, 8'(PIX_MAX) - s2_a};
        mt_c = {8'd0, s2_v} * {8'd0, 8'(PIX_MAX) - s2_b};
    end

    // Stage-3 register
    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            s3_valid <= 1'b0;
            s3_sec   <= SEC_0;
            s3_v     <= '0;
            s3_mp    <= '0;
            s3_mq    <= '0;
            s3_mt    <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_sec   <= s2_sec;
            s3_v     <= s2_v;
            s3_mp    <= mp_c;
            s3_mq    <= mq_c;
            s3_mt    <= mt_c;
        end
    end

    // ---------------- S4: divide by 255 and pick channel order -----------
    logic [7:0] p_c;
    logic [7:0] q_c;
    logic [7:0] t_c;
    logic [7:0] r_c;
    logic [7:0] g_c;
    logic [7:0] b_out_c;

    div255 u_div_p (.x(s3_mp), .q(p_c));
    div255 u_div_q (.x(s3_mq), .q(q_c));
    div255 u_div_t (.x(s3_mt), .q(t_c));

    // Sector-dependent assignment of V/p/q/t onto R,G,B
    always_comb begin
        r_c     = s3_v;
        g_c     = t_c;
        b_out_c = p_c;
        case (s3_sec)
            SEC_0: begin r_c = s3_v; g_c = t_c;  b_out_c = p_c;  end
            SEC_1: begin r_c = q_c;  g_c = s3_v; b_out_c = p_c;  end
            SEC_2: begin r_c = p_c;  g_c = s3_v; b_out_c = t_c;  end
            SEC_3: begin r_c = p_c;  g_c = q_c;  b_out_c = s3_v; end
            SEC_4: begin r_c = t_c;  g_c = p_c;  b_out_c = s3_v; end
            SEC_5: begin r_c = s3_v; g_c = p_c;  b_out_c = q_c;  end
            default: begin r_c = s3_v; g_c = t_c; b_out_c = p_c; end
        endcase
    end

    // Output register
    always_ff @(posedge clk_Image_Process or negedge Rst) begin
        if (!Rst) begin
            RGB_Valid  <= 1'b0;
            RGB_Data_R <= '0;
            RGB_Data_G <= '0;
            RGB_Data_B <= '0;
        end else begin
            RGB_Valid  <= s3_valid;
            RGB_Data_R <= r_c;
            RGB_Data_G <= g_c;
            RGB_Data_B <= b_out_c;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hsv2rgb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hsv2rgb
//  Description : Directed self-checking bench for hsv2rgb and div255.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hsv2rgb;

    logic       clk_Image_Process = 1'b0;
    logic       Rst = 1'b0;
    logic       HSV_Valid = 1'b0;
    logic [8:0] HSV_H = '0;
    logic [7:0] HSV_S = '0;
    logic [7:0] HSV_V = '0;
    logic       RGB_Valid;
    logic [7:0] RGB_Data_R;
    logic [7:0] RGB_Data_G;
    logic [7:0] RGB_Data_B;
    logic [2:0] Delay_Num;

    logic [15:0] div_x = '0;
    logic [7:0]  div_q;

    int n_vec = 0;
    int n_err = 0;

    hsv2rgb dut (
        .clk_Image_Process (clk_Image_Process),
        .Rst               (Rst),
        .HSV_Valid         (HSV_Valid),
        .HSV_H             (HSV_H),
        .HSV_S             (HSV_S),
        .HSV_V             (HSV_V),
        .RGB_Valid         (RGB_Valid),
        .RGB_Data_R        (RGB_Data_R),
        .RGB_Data_G        (RGB_Data_G),
        .RGB_Data_B        (RGB_Data_B),
        .Delay_Num         (Delay_Num)
    );

    div255 u_div (.x(div_x), .q(div_q));

    always #5 clk_Image_Process = ~clk_Image_Process;

    // Stream table: H, S, V and expected R, G, B
    logic [8:0] sh [6] = '{9'd0,   9'd120, 9'd240, 9'd60,  9'd30,  9'd200};
    logic [7:0] ss [6] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0};
    logic [7:0] sv [6] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd128};
    logic [7:0] sr [6] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd255, 8'd128};
    logic [7:0] sg [6] = '{8'd0,   8'd255, 8'd0,   8'd255, 8'd128, 8'd128};
    logic [7:0] sb [6] = '{8'd0,   8'd0,   8'd255, 8'd0,   8'd0,   8'd128};

    // One pixel with one-cycle valid; returns outputs after 4 clocks and the
    // valid seen one clock early
    task automatic run_vec(input logic [8:0] h, input logic [7:0] s, input logic [7:0] v,
                           output logic [7:0] r, output logic [7:0] g, output logic [7:0] b,
                           output logic vld, output logic early_vld, output logic [2:0] dn);
        @(negedge clk_Image_Process);
        HSV_Valid = 1'b1; HSV_H = h; HSV_S = s; HSV_V = v;
        @(negedge clk_Image_Process);
        HSV_Valid = 1'b0;
        repeat (2) @(negedge clk_Image_Process);
        early_vld = RGB_Valid;
        @(negedge clk_Image_Process);
        r = RGB_Data_R; g = RGB_Data_G; b = RGB_Data_B; vld = RGB_Valid; dn = Delay_Num;
    endtask

    task automatic test_reset();
        HSV_Valid = 1'b1; HSV_H = 9'd10; HSV_S = 8'd200; HSV_V = 8'd200;
        repeat (3) @(negedge clk_Image_Process);
        n_vec++;
        if (RGB_Valid !== 1'b0 || RGB_Data_R !== 8'd0 || RGB_Data_G !== 8'd0 ||
            RGB_Data_B !== 8'd0 || Delay_Num !== 3'd4) begin
            n_err++;
            $display("FAIL reset_state: got v=%b rgb=%0d,%0d,%0d dn=%0d want v=0 rgb=0,0,0 dn=4",
                     RGB_Valid, RGB_Data_R, RGB_Data_G, RGB_Data_B, Delay_Num);
        end
        HSV_Valid = 1'b0;
        Rst = 1'b1;
        repeat (6) @(negedge clk_Image_Process);
        n_vec++;
        if (RGB_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_valid: got %b want 0", RGB_Valid);
        end
    endtask

    task automatic test_primaries();
        logic [8:0] th [4] = '{9'd0, 9'd120, 9'd240, 9'd60};
        logic [7:0] er [4] = '{8'd255, 8'd0, 8'd0, 8'd255};
        logic [7:0] eg [4] = '{8'd0, 8'd255, 8'd0, 8'd255};
        logic [7:0] eb [4] = '{8'd0, 8'd0, 8'd255, 8'd0};
        logic [7:0] r, g, b;
        logic vld, ev;
        logic [2:0] dn;
        for (int i = 0; i < 4; i++) begin
            run_vec(th[i], 8'd255, 8'd255, r, g, b, vld, ev, dn);
            n_vec++;
            if (vld !== 1'b1 || ev !== 1'b0 || r !== er[i] || g !== eg[i] || b !== eb[i] || dn !== 3'd4) begin
                n_err++;
                $display("FAIL primary_h%0d: got v=%b early=%b rgb=%0d,%0d,%0d dn=%0d want v=1 early=0 rgb=%0d,%0d,%0d dn=4",
                         th[i], vld, ev, r, g, b, dn, er[i], eg[i], eb[i]);
            end
        end
    endtask

    task automatic test_grey_black();
        logic [7:0] r, g, b;
        logic vld, ev;
        logic [2:0] dn;
        run_vec(9'd200, 8'd0, 8'd128, r, g, b, vld, ev, dn);
        n_vec++;
        if (vld !== 1'b1 || r !== 8'd128 || g !== 8'd128 || b !== 8'd128) begin
            n_err++;
            $display("FAIL grey: got v=%b rgb=%0d,%0d,%0d want v=1 rgb=128,128,128", vld, r, g, b);
        end
        run_vec(9'd77, 8'd255, 8'd0, r, g, b, vld, ev, dn);
        n_vec++;
        if (vld !== 1'b1 || r !== 8'd0 || g !== 8'd0 || b !== 8'd0) begin
            n_err++;
            $display("FAIL black: got v=%b rgb=%0d,%0d,%0d want v=1 rgb=0,0,0", vld, r, g, b);
        end
    endtask

    task automatic test_mid_and_clamp();
        logic [7:0] r, g, b;
        logic vld, ev;
        logic [2:0] dn;
        run_vec(9'd30, 8'd255, 8'd255, r, g, b, vld, ev, dn);
        n_vec++;
        if (vld !== 1'b1 || r !== 8'd255 || g !== 8'd128 || b !== 8'd0) begin
            n_err++;
            $display("FAIL mid_sector_h30: got v=%b rgb=%0d,%0d,%0d want v=1 rgb=255,128,0", vld, r, g, b);
        end
        run_vec(9'd400, 8'd255, 8'd255, r, g, b, vld, ev, dn);
        n_vec++;
        if (vld !== 1'b1 || r !== 8'd255 || g !== 8'd0 || b !== 8'd5) begin
            n_err++;
            $display("FAIL clamp_h400: got v=%b rgb=%0d,%0d,%0d want v=1 rgb=255,0,5", vld, r, g, b);
        end
        run_vec(9'd511, 8'd255, 8'd255, r, g, b, vld, ev, dn);
        n_vec++;
        if (vld !== 1'b1 || r !== 8'd255 || g !== 8'd0 || b !== 8'd5) begin
            n_err++;
            $display("FAIL clamp_h511: got v=%b rgb=%0d,%0d,%0d want v=1 rgb=255,0,5", vld, r, g, b);
        end
    endtask

    // Six back-to-back pixels: valid run of exactly 6, data in order
    task automatic test_back_to_back();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk_Image_Process);
            n_vec++;
            if (RGB_Valid !== ((c >= 4) && (c < 10))) begin
                n_err++;
                $display("FAIL b2b_valid_c%0d: got %b want %b", c, RGB_Valid, (c >= 4) && (c < 10));
            end else if (c >= 4 && c < 10 &&
                         (RGB_Data_R !== sr[c-4] || RGB_Data_G !== sg[c-4] || RGB_Data_B !== sb[c-4])) begin
                n_err++;
                $display("FAIL b2b_data_%0d: got %0d,%0d,%0d want %0d,%0d,%0d", c - 4,
                         RGB_Data_R, RGB_Data_G, RGB_Data_B, sr[c-4], sg[c-4], sb[c-4]);
            end
            if (c < 6) begin
                HSV_Valid = 1'b1; HSV_H = sh[c]; HSV_S = ss[c]; HSV_V = sv[c];
            end else begin
                HSV_Valid = 1'b0;
            end
        end
    endtask

    // Valid pattern 1,1,0,1,1 must reappear unchanged four clocks later
    task automatic test_gap();
        logic pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic exp_v;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_Image_Process);
            exp_v = (c >= 4 && c < 9) ? pat[c-4] : 1'b0;
            n_vec++;
            if (RGB_Valid !== exp_v) begin
                n_err++;
                $display("FAIL gap_valid_c%0d: got %b want %b", c, RGB_Valid, exp_v);
            end else if (exp_v &&
                         (RGB_Data_R !== sr[c-4] || RGB_Data_G !== sg[c-4] || RGB_Data_B !== sb[c-4])) begin
                n_err++;
                $display("FAIL gap_data_%0d: got %0d,%0d,%0d want %0d,%0d,%0d", c - 4,
                         RGB_Data_R, RGB_Data_G, RGB_Data_B, sr[c-4], sg[c-4], sb[c-4]);
            end
            if (c < 5) begin
                HSV_Valid = pat[c]; HSV_H = sh[c]; HSV_S = ss[c]; HSV_V = sv[c];
            end else begin
                HSV_Valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] r, g, b;
        logic vld, ev;
        logic [2:0] dn;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_Image_Process);
            HSV_Valid = 1'b1; HSV_H = sh[c]; HSV_S = ss[c]; HSV_V = sv[c];
        end
        @(negedge clk_Image_Process);
        HSV_Valid = 1'b0;
        n_vec++;
        if (RGB_Valid !== 1'b1 || RGB_Data_R !== sr[1] || RGB_Data_G !== sg[1] || RGB_Data_B !== sb[1]) begin
            n_err++;
            $display("FAIL pre_reset_out: got v=%b rgb=%0d,%0d,%0d want v=1 rgb=%0d,%0d,%0d",
                     RGB_Valid, RGB_Data_R, RGB_Data_G, RGB_Data_B, sr[1], sg[1], sb[1]);
        end
        #2 Rst = 1'b0;
        #1;
        n_vec++;
        if (RGB_Valid !== 1'b0 || RGB_Data_R !== 8'd0 || RGB_Data_G !== 8'd0 || RGB_Data_B !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b rgb=%0d,%0d,%0d want v=0 rgb=0,0,0",
                     RGB_Valid, RGB_Data_R, RGB_Data_G, RGB_Data_B);
        end
        repeat (2) @(negedge clk_Image_Process);
        Rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_Image_Process);
            n_vec++;
            if (RGB_Valid !== 1'b0) begin
                n_err++;
                $display("FAIL stale_valid_c%0d: got %b want 0", c, RGB_Valid);
            end
        end
        run_vec(9'd240, 8'd255, 8'd255, r, g, b, vld, ev, dn);
        n_vec++;
        if (vld !== 1'b1 || ev !== 1'b0 || r !== 8'd0 || g !== 8'd0 || b !== 8'd255) begin
            n_err++;
            $display("FAIL post_reset_pixel: got v=%b early=%b rgb=%0d,%0d,%0d want v=1 early=0 rgb=0,0,255",
                     vld, ev, r, g, b);
        end
    endtask

    task automatic test_div255();
        for (int x = 0; x <= 65025; x++) begin
            div_x = 16'(x);
            #1;
            n_vec++;
            if (div_q !== 8'(x / 255)) begin
                n_err++;
                $display("FAIL div255_x%0d: got %0d want %0d", x, div_q, x / 255);
            end
        end
    endtask

    initial begin
        test_reset();
        test_primaries();
        test_grey_black();
        test_mid_and_clamp();
        test_back_to_back();
        test_gap();
        test_reset_midstream();
        test_div255();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
